// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of any depth with optional first-word-fall-through read,
// programmable almost flags, occupancy output and sticky overflow/underflow errors.
module sync_fifo_flags #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 10,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned ADD_W     = $clog2(DEPTH),
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADD_W-1:0] LastPtr = ADD_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AfCnt   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AeCnt   = CNT_W'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADD_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADD_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_accept;
    logic             rd_accept;

    // Flags come straight from the registered count, never from this cycle's requests.
    assign full         = (count_q == FullCnt);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfCnt);
    assign almost_empty = (count_q <= AeCnt);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Explicit wrap so non-power-of-2 depths work.
        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q && !clr_err) || (wr_en && full);
        underflow_d = (underflow_q && !clr_err) || (rd_en && empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= din;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign dout       = mem[rd_ptr_q];
        assign dout_valid = !empty;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;
        logic              dout_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_valid_q <= rd_accept;
                if (rd_accept) begin
                    dout_q <= mem[rd_ptr_q];
                end
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a standard-read and an FWFT instance share
// identical stimulus; a vector table covers fill/drain, hand sequences the corners.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] din;

    logic [7:0] dout0, dout1;
    logic       dv0, dv1;
    logic       full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1;
    logic [3:0] count0, count1;
    logic       ovf0, ovf1, unf0, unf1;

    int total = 0;
    int bad   = 0;

    sync_fifo_flags #(.DATA_W(8), .DEPTH(10), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
        .dout(dout0), .dout_valid(dv0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_flags #(.DATA_W(8), .DEPTH(10), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
        .dout(dout1), .dout_valid(dv1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
        logic       dv0;
        logic [7:0] dout0;
        logic       dv1;
        logic [7:0] dout1;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Occupancy and all flags of both instances against an expected count.
    task automatic check_cnt(input string tag, input int exp_cnt);
        check({tag, " count"}, 32'(count0), 32'(exp_cnt));
        check({tag, " full"}, 32'(full0), 32'(exp_cnt == 10));
        check({tag, " empty"}, 32'(empty0), 32'(exp_cnt == 0));
        check({tag, " almost_full"}, 32'(af0), 32'(exp_cnt >= 8));
        check({tag, " almost_empty"}, 32'(ae0), 32'(exp_cnt <= 2));
        check({tag, " fwft count"}, 32'(count1), 32'(exp_cnt));
    endtask

    task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        clr_err = c;
        din     = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] popped;
        bit         rd_ok, wr_ok;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check_cnt("reset", 0);
        check("reset overflow", 32'(ovf0), 32'd0);
        check("reset underflow", 32'(unf0), 32'd0);
        check("reset dout", 32'(dout0), 32'd0);
        check("reset dout_valid", 32'(dv0), 32'd0);
        check("reset fwft dout_valid", 32'(dv1), 32'd0);

        // Fill 1..10, one overflowing write, drain 10, one underflowing read.
        for (int k = 1; k <= 10; k++) begin
            vecs[k-1] = '{1'b1, 1'b0, 8'(k), 4'(k), 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd1};
        end
        vecs[10] = '{1'b1, 1'b0, 8'd11, 4'd10, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd1};
        for (int r = 1; r <= 10; r++) begin
            vecs[10+r] = '{1'b0, 1'b1, 8'd0, 4'(10 - r), 1'b1, 1'b0, 1'b1, 8'(r),
                           (r < 10), 8'(r + 1)};
        end
        vecs[21] = '{1'b0, 1'b1, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd10, 1'b0, 8'd0};

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].din);
            tick();
            check_cnt($sformatf("vec%0d", i), int'(vecs[i].cnt));
            check($sformatf("vec%0d overflow", i), 32'(ovf0), 32'(vecs[i].ovf));
            check($sformatf("vec%0d underflow", i), 32'(unf0), 32'(vecs[i].unf));
            check($sformatf("vec%0d fwft overflow", i), 32'(ovf1), 32'(vecs[i].ovf));
            check($sformatf("vec%0d dout_valid", i), 32'(dv0), 32'(vecs[i].dv0));
            check($sformatf("vec%0d dout", i), 32'(dout0), 32'(vecs[i].dout0));
            check($sformatf("vec%0d fwft dout_valid", i), 32'(dv1), 32'(vecs[i].dv1));
            if (vecs[i].dv1) begin
                check($sformatf("vec%0d fwft dout", i), 32'(dout1), 32'(vecs[i].dout1));
            end
        end

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("clr overflow", 32'(ovf0), 32'd0);
        check("clr underflow", 32'(unf0), 32'd0);

        // Simultaneous read+write at count 5, then at full.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(20 + k));
            tick();
        end
        check_cnt("fill5", 5);
        drive(1'b1, 1'b1, 1'b0, 8'd25);
        tick();
        check_cnt("rw at 5", 5);
        check("rw at 5 dout", 32'(dout0), 32'd20);
        check("rw at 5 dout_valid", 32'(dv0), 32'd1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(26 + k));
            tick();
        end
        check_cnt("refill", 10);
        drive(1'b1, 1'b1, 1'b0, 8'd99);
        tick();
        check_cnt("rw at full", 9);
        check("rw at full overflow", 32'(ovf0), 32'd1);
        check("rw at full dout", 32'(dout0), 32'd21);
        for (int j = 0; j < 9; j++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            check($sformatf("drain%0d dout", j), 32'(dout0), 32'(22 + j));
        end
        check_cnt("drained", 0);
        check("drained underflow", 32'(unf0), 32'd0);

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();

        // Low-occupancy streaming; 25 writes forces several pointer wraps.
        q.delete();
        for (int i = 0; i < 27; i++) begin
            drive(i < 25, i >= 2, 1'b0, 8'(i * 13 + 5));
            rd_ok = rd_en && (q.size() > 0);
            wr_ok = wr_en && (q.size() < 10);
            tick();
            if (rd_ok) begin
                popped = q.pop_front();
                check($sformatf("wrap%0d dout", i), 32'(dout0), 32'(popped));
            end
            if (wr_ok) q.push_back(din);
            check($sformatf("wrap%0d dout_valid", i), 32'(dv0), 32'(rd_ok));
            check($sformatf("wrap%0d count", i), 32'(count0), 32'(q.size()));
            if (q.size() > 0) begin
                check($sformatf("wrap%0d fwft dout", i), 32'(dout1), 32'(q[0]));
            end
        end
        check("wrap underflow", 32'(unf0), 32'd0);

        // FWFT presentation latency and pop.
        drive(1'b1, 1'b0, 1'b0, 8'hA5);
        tick();
        check("fwft dout_valid after write", 32'(dv1), 32'd1);
        check("fwft dout after write", 32'(dout1), 32'hA5);
        check("std no dout_valid after write", 32'(dv0), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check("fwft dout_valid after pop", 32'(dv1), 32'd0);
        check("std dout after read", 32'(dout0), 32'hA5);
        check("std dout_valid pulse", 32'(dv0), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("std dout_valid pulse end", 32'(dv0), 32'd0);
        check("std dout hold", 32'(dout0), 32'hA5);

        // Asynchronous reset in mid-burst at count 6 with overflow set.
        for (int k = 0; k < 11; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(40 + k));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 8'h77);
        check_cnt("pre-reset", 6);
        check("pre-reset overflow", 32'(ovf0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_cnt("async reset", 0);
        check("async reset overflow", 32'(ovf0), 32'd0);
        check("async reset dout", 32'(dout0), 32'd0);
        check("async reset dout_valid", 32'(dv0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check_cnt("after reset", 0);

        // Set wins over clear.
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check("underflow set", 32'(unf0), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        check("underflow set wins", 32'(unf0), 32'd1);
        check("fwft underflow set wins", 32'(unf1), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("underflow cleared", 32'(unf0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
